// File: rtl/tl_ul_pkg.sv
// Shared TL-UL constants, response-slot state encoding and opcode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tl_ul_pkg;

    // Data path geometry
    localparam int TL_DATA_W = 32;
    localparam int TL_LANES  = TL_DATA_W / 8;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // The only access size this responder supports: one 32-bit word
    localparam logic [1:0] TL_SIZE_WORD = 2'd2;

    // Single response slot: EMPTY means d_valid low, FULL means d_valid high
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    // Response fields that do not depend on the source-ID width
    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           size;
        logic                 denied;
        logic [TL_DATA_W-1:0] data;
    } d_fix_t;

    function automatic logic is_put_op(input logic [2:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return is_put_op(op) || (op == A_GET);
    endfunction

endpackage

// File: rtl/tl_ul_regfile.sv
// NREGS x 32-bit register file with byte-lane masked write and combinational read.
// Latency: write lands on the clock edge; read is same-cycle combinational.
// Backpressure: none; the caller qualifies i_we with its own handshake.
module tl_ul_regfile
    import tl_ul_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_we,
    input  logic [1:0]           i_widx,
    input  logic [TL_LANES-1:0]  i_wmask,
    input  logic [TL_DATA_W-1:0] i_wdata,
    input  logic [1:0]           i_ridx,
    output logic [TL_DATA_W-1:0] o_rdata
);

    logic [TL_DATA_W-1:0] r_regs [NREGS];

    // Register storage: clear on reset, otherwise merge enabled byte lanes into the selected word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < NREGS; i++) begin
                if (i_widx == 2'(i)) begin
                    for (int b = 0; b < TL_LANES; b++) begin
                        if (i_wmask[b]) begin
                            r_regs[i][8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read mux: an index with no backing register reads as zero
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_ridx == 2'(i)) begin
                o_rdata = r_regs[i];
            end
        end
    end

endmodule

// File: rtl/tl_ul_reg_responder.sv
// TL-UL slave exposing NREGS 32-bit registers, one outstanding response slot.
// Latency: response valid on the edge after the A accept (1 cycle).
// Backpressure: a_ready = !d_valid || d_ready, so a consumed slot refills with no bubble.
module tl_ul_reg_responder
    import tl_ul_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int SRC_W = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    // A channel
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [2:0]           a_opcode,
    input  logic [1:0]           a_size,
    input  logic [SRC_W-1:0]     a_source,
    input  logic [3:0]           a_address,
    input  logic [TL_LANES-1:0]  a_mask,
    input  logic [TL_DATA_W-1:0] a_data,
    // D channel
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic [2:0]           d_opcode,
    output logic [1:0]           d_size,
    output logic [SRC_W-1:0]     d_source,
    output logic                 d_denied,
    output logic [TL_DATA_W-1:0] d_data
);

    rsp_state_t           r_state;
    rsp_state_t           w_state_nxt;
    d_fix_t               r_rsp;
    d_fix_t               w_rsp;
    logic [SRC_W-1:0]     r_source;

    logic                 w_a_fire;
    logic                 w_d_fire;
    logic [1:0]           w_idx;
    logic                 w_idx_oob;
    logic                 w_denied;
    logic                 w_is_get;
    logic                 w_wr_en;
    logic [TL_DATA_W-1:0] w_rdata;

    // Handshakes; a_ready and d_valid come from the output process below
    assign w_a_fire = a_valid && a_ready;
    assign w_d_fire = d_valid && d_ready;

    // Request decode: word index from address bits [3:2]
    assign w_idx     = a_address[3:2];
    assign w_idx_oob = ({1'b0, w_idx} >= 3'(NREGS));
    assign w_is_get  = (a_opcode == A_GET);
    assign w_denied  = (a_address[1:0] != 2'b00) || w_idx_oob ||
                       (a_size != TL_SIZE_WORD) || !is_legal_op(a_opcode);
    assign w_wr_en   = w_a_fire && !w_denied && is_put_op(a_opcode);

    tl_ul_regfile #(
        .NREGS   (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .i_we    (w_wr_en),
        .i_widx  (w_idx),
        .i_wmask (a_mask),
        .i_wdata (a_data),
        .i_ridx  (w_idx),
        .o_rdata (w_rdata)
    );

    // Slot state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: an accept always (re)fills the slot; a lone D fire drains it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_a_fire) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_a_fire) begin
                    w_state_nxt = ST_FULL;
                end else if (w_d_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Outputs derived from the slot state
    always_comb begin
        d_valid = (r_state == ST_FULL);
        a_ready = (r_state == ST_EMPTY) || d_ready;
    end

    // Response build: Get answers with data unless denied; everything else is a plain ack
    always_comb begin
        w_rsp        = '0;
        w_rsp.size   = a_size;
        w_rsp.denied = w_denied;
        w_rsp.opcode = w_is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
        if (w_is_get && !w_denied) begin
            w_rsp.data = w_rdata;
        end
    end

    // Response register: loaded only on accept so D holds steady under backpressure
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp    <= '0;
            r_source <= '0;
        end else if (w_a_fire) begin
            r_rsp    <= w_rsp;
            r_source <= a_source;
        end
    end

    assign d_opcode = r_rsp.opcode;
    assign d_size   = r_rsp.size;
    assign d_denied = r_rsp.denied;
    assign d_data   = r_rsp.data;
    assign d_source = r_source;

endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// Scoreboard bench for tl_ul_reg_responder: a reference model predicts each response at accept time.
// Latency: expects the response on the edge after each accept.
// Backpressure: exercises d_ready stalls, back-to-back bursts and async reset mid-response.
module tb_tl_ul_reg_responder;
    import tl_ul_pkg::*;

    localparam int NREGS = 4;
    localparam int SRC_W = 4;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic [2:0]        a_opcode = '0;
    logic [1:0]        a_size = '0;
    logic [SRC_W-1:0]  a_source = '0;
    logic [3:0]        a_address = '0;
    logic [3:0]        a_mask = '0;
    logic [31:0]       a_data = '0;
    logic              d_valid;
    logic              d_ready = 1'b1;
    logic [2:0]        d_opcode;
    logic [1:0]        d_size;
    logic [SRC_W-1:0]  d_source;
    logic              d_denied;
    logic [31:0]       d_data;

    always #5 clock = ~clock;

    tl_ul_reg_responder #(
        .NREGS     (NREGS),
        .SRC_W     (SRC_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data)
    );

    typedef struct packed {
        logic [2:0]       op;
        logic [1:0]       size;
        logic [SRC_W-1:0] src;
        logic             den;
        logic [31:0]      data;
    } exp_t;

    exp_t        sb_q[$];
    int          fire_cyc[$];
    logic [31:0] m_regs [NREGS];
    logic [31:0] last_d_data = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: predict the response and apply any write, in acceptance order
    task automatic model_req(input logic [2:0] op, input logic [1:0] size, input logic [SRC_W-1:0] src,
                             input logic [3:0] addr, input logic [3:0] mask, input logic [31:0] data);
        exp_t e;
        int   idx;
        idx    = int'(addr[3:2]);
        e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
        e.size = size;
        e.src  = src;
        e.den  = (addr[1:0] != 2'b00) || (idx >= NREGS) || (size != 2'd2) ||
                 !((op == 3'd0) || (op == 3'd1) || (op == 3'd4));
        e.data = '0;
        if (!e.den && op == 3'd4) begin
            e.data = m_regs[idx];
        end
        if (!e.den && op != 3'd4) begin
            for (int b = 0; b < 4; b++) begin
                if (mask[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        sb_q.push_back(e);
    endtask

    // Present a request and hold it until accepted; leaves a_valid high for back-to-back use
    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [SRC_W-1:0] src,
                        input logic [3:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        output int waits);
        bit ok;
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data;
        waits = 0;
        ok = 1'b0;
        while (!ok && waits <= 50) begin
            @(negedge clock);
            if (a_ready) ok = 1'b1;
            else waits++;
        end
        if (ok) begin
            model_req(op, size, src, addr, mask, data);
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: a_ready low for %0d cycles, expected acceptance", waits);
        end
        @(posedge clock); #1;
    endtask

    // Drop a_valid and scribble the other A fields; they must be ignored
    task automatic a_idle();
        a_valid = 1'b0;
        a_opcode = 3'($urandom); a_size = 2'($urandom); a_source = SRC_W'($urandom);
        a_address = 4'($urandom); a_mask = 4'($urandom); a_data = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
        end
    endtask

    // Monitor: every D fire is compared against the oldest prediction
    always @(negedge clock) begin
        automatic exp_t e;
        cyc++;
        if (reset_n && d_valid && d_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_rsp: d_valid with source %0d, expected no response", d_source);
            end else begin
                e = sb_q.pop_front();
                chk_eq("d_opcode", 32'(d_opcode), 32'(e.op));
                chk_eq("d_size",   32'(d_size),   32'(e.size));
                chk_eq("d_source", 32'(d_source), 32'(e.src));
                chk_eq("d_denied", 32'(d_denied), 32'(e.den));
                chk_eq("d_data",   d_data,        e.data);
                last_d_data = d_data;
                fire_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          wsum;
        int          n;
        logic [4:0]  addr5;
        logic [2:0]  ops [6];
        ops = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd2, 3'd4};
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;

        // Reset state, including a_ready high while in reset
        #2;
        chk_eq("rst_d_valid", 32'(d_valid), 32'd0);
        chk_eq("rst_a_ready", 32'(a_ready), 32'd1);
        chk_eq("rst_d_data",  d_data,       32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk_eq("rst_a_ready_hold", 32'(a_ready), 32'd1);
        reset_n = 1'b1;

        // Full write then read back
        send(3'd0, 2'd2, 4'd1, 4'h4, 4'hF, 32'hDEADBEEF, w);
        send(3'd4, 2'd2, 4'd2, 4'h4, 4'h0, 32'h0, w);
        a_idle();
        drain();
        chk_eq("get_full_word", last_d_data, 32'hDEADBEEF);

        // Partial write merges low half
        send(3'd1, 2'd2, 4'd3, 4'h4, 4'h3, 32'h00001234, w);
        a_idle();
        @(posedge clock); #1;
        send(3'd4, 2'd2, 4'd4, 4'h4, 4'h0, 32'h0, w);
        a_idle();
        drain();
        chk_eq("get_partial_word", last_d_data, 32'hDEAD1234);

        // PutFull with sparse mask honoured per lane
        send(3'd0, 2'd2, 4'd5, 4'h8, 4'h5, 32'hAABBCCDD, w);
        send(3'd4, 2'd2, 4'd6, 4'h8, 4'h0, 32'h0, w);
        a_idle();
        drain();
        chk_eq("get_sparse_put", last_d_data, 32'h00BB00DD);

        // Denied requests: misaligned, bad size, illegal opcode, misaligned Put
        send(3'd4, 2'd2, 4'd7, 4'h2, 4'h0, 32'h0, w);
        send(3'd0, 2'd2, 4'd8, 4'h5, 4'hF, 32'h11111111, w);
        send(3'd4, 2'd1, 4'd9, 4'h4, 4'h0, 32'h0, w);
        send(3'd2, 2'd2, 4'd10, 4'h4, 4'hF, 32'h22222222, w);
        // Only the low 4 bits of this 5-bit address reach the port; the model predicts from those
        addr5 = 5'h10;
        send(3'd4, 2'd2, 4'd11, addr5[3:0], 4'h0, 32'h0, w);
        send(3'd4, 2'd2, 4'd12, 4'h4, 4'h0, 32'h0, w);
        a_idle();
        drain();
        chk_eq("reg_unchanged_after_deny", last_d_data, 32'hDEAD1234);

        // Backpressure: slot held for 5 cycles while a new request waits
        d_ready = 1'b0;
        send(3'd4, 2'd2, 4'd13, 4'h4, 4'h0, 32'h0, w);
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 2'd2; a_source = 4'd14;
        a_address = 4'h8; a_mask = 4'h0; a_data = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk_eq("stall_a_ready",  32'(a_ready),  32'd0);
            chk_eq("stall_d_valid",  32'(d_valid),  32'd1);
            chk_eq("stall_d_data",   d_data,        sb_q[0].data);
            chk_eq("stall_d_source", 32'(d_source), 32'(sb_q[0].src));
        end
        @(posedge clock); #1;
        d_ready = 1'b1;
        send(3'd4, 2'd2, 4'd14, 4'h8, 4'h0, 32'h0, w);
        chk_eq("release_same_cycle_accept", 32'(w), 32'd0);
        a_idle();
        drain();

        // Burst of 8 Gets, one per cycle
        wsum = 0;
        for (int k = 0; k < 8; k++) begin
            send(3'd4, 2'd2, SRC_W'(k + 8), 4'((k % 4) * 4), 4'h0, 32'h0, w);
            wsum += w;
        end
        a_idle();
        drain();
        chk_eq("burst_no_stall", 32'(wsum), 32'd0);
        n = fire_cyc.size();
        chk_eq("burst_span_cycles", 32'(fire_cyc[n-1] - fire_cyc[n-8]), 32'd7);

        // Mixed random traffic including illegal opcodes and sizes
        for (int k = 0; k < 16; k++) begin
            send(ops[$urandom_range(0, 5)], ($urandom_range(0, 5) == 0) ? 2'd1 : 2'd2,
                 SRC_W'($urandom), {2'($urandom), ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00},
                 4'($urandom), $urandom, w);
            if ($urandom_range(0, 2) == 0) begin
                a_idle();
                @(posedge clock); #1;
            end
        end
        a_idle();
        drain();

        // Asynchronous reset while a response is pending
        d_ready = 1'b0;
        send(3'd4, 2'd2, 4'd3, 4'h8, 4'h0, 32'h0, w);
        a_idle();
        #1;
        chk_eq("pre_reset_d_valid", 32'(d_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_eq("async_rst_d_valid", 32'(d_valid), 32'd0);
        chk_eq("async_rst_d_data",  d_data,       32'd0);
        chk_eq("async_rst_a_ready", 32'(a_ready), 32'd1);
        sb_q.delete();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        d_ready = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        send(3'd4, 2'd2, 4'd1, 4'h0, 4'h0, 32'h0, w);
        send(3'd4, 2'd2, 4'd2, 4'h4, 4'h0, 32'h0, w);
        a_idle();
        drain();
        chk_eq("post_reset_reg1", last_d_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
